// File: rtl/rate_pkg.sv
// Shared types and defaults for the rate period meter.
// Nominal periods are the rate divider load values plus one.
package rate_pkg;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam int unsigned RATE_WIDTH    = 28;
  localparam int unsigned RATE_PERIOD_0 = 4;
  localparam int unsigned RATE_PERIOD_1 = 50_000_000;
  localparam int unsigned RATE_PERIOD_2 = 100_000_000;
  localparam int unsigned RATE_PERIOD_3 = 200_000_000;

endpackage

// File: rtl/rate_classifier.sv
// Combinational mapping of a measured period onto the nearest divider rate code.
// Windows are PERIOD_n +/- TOL, evaluated one bit wider than the period.
module rate_classifier
  import rate_pkg::*;
#(
  parameter int unsigned WIDTH    = RATE_WIDTH,
  parameter int unsigned TOL      = 2,
  parameter int unsigned PERIOD_0 = RATE_PERIOD_0,
  parameter int unsigned PERIOD_1 = RATE_PERIOD_1,
  parameter int unsigned PERIOD_2 = RATE_PERIOD_2,
  parameter int unsigned PERIOD_3 = RATE_PERIOD_3
) (
  input  logic [WIDTH-1:0] period,
  output logic [1:0]       rate_code,
  output logic             rate_match
);

  typedef logic [WIDTH:0] wide_t;

  localparam wide_t NOM_0 = wide_t'(PERIOD_0);
  localparam wide_t NOM_1 = wide_t'(PERIOD_1);
  localparam wide_t NOM_2 = wide_t'(PERIOD_2);
  localparam wide_t NOM_3 = wide_t'(PERIOD_3);
  localparam wide_t TOL_W = wide_t'(TOL);

  // Lower bound saturates at zero when the tolerance exceeds the nominal period.
  function automatic logic in_window(input wide_t p, input wide_t nom, input wide_t tol);
    wide_t lo;
    wide_t hi;
    lo = (nom > tol) ? nom - tol : '0;
    hi = nom + tol;
    return (p >= lo) && (p <= hi);
  endfunction

  wide_t period_w;
  assign period_w = {1'b0, period};

  always_comb begin
    rate_code  = 2'b00;
    rate_match = 1'b0;
    if (in_window(period_w, NOM_0, TOL_W)) begin
      rate_code  = 2'b00;
      rate_match = 1'b1;
    end else if (in_window(period_w, NOM_1, TOL_W)) begin
      rate_code  = 2'b01;
      rate_match = 1'b1;
    end else if (in_window(period_w, NOM_2, TOL_W)) begin
      rate_code  = 2'b10;
      rate_match = 1'b1;
    end else if (in_window(period_w, NOM_3, TOL_W)) begin
      rate_code  = 2'b11;
      rate_match = 1'b1;
    end
  end

endmodule

// File: rtl/rate_period_meter.sv
// Measures cycles between rising edges of a strobe and classifies the period
// against the four divider rate settings; sticky timeout on counter saturation.
module rate_period_meter
  import rate_pkg::*;
#(
  parameter int unsigned WIDTH    = RATE_WIDTH,
  parameter int unsigned TOL      = 2,
  parameter int unsigned PERIOD_0 = RATE_PERIOD_0,
  parameter int unsigned PERIOD_1 = RATE_PERIOD_1,
  parameter int unsigned PERIOD_2 = RATE_PERIOD_2,
  parameter int unsigned PERIOD_3 = RATE_PERIOD_3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic [1:0]       rate_code,
  output logic             rate_match,
  output logic             timeout
);

  state_t           state, state_d;
  logic [WIDTH-1:0] cnt, cnt_d;
  logic             prev;
  logic             rise;
  logic [WIDTH-1:0] period_d;
  logic             valid_d;
  logic [1:0]       code_d, cls_code;
  logic             match_d, cls_match;
  logic             timeout_d;

  assign rise = pulse_in & ~prev;

  // The counter value at an edge is the period being captured.
  rate_classifier #(
    .WIDTH    (WIDTH),
    .TOL      (TOL),
    .PERIOD_0 (PERIOD_0),
    .PERIOD_1 (PERIOD_1),
    .PERIOD_2 (PERIOD_2),
    .PERIOD_3 (PERIOD_3)
  ) u_classifier (
    .period     (cnt),
    .rate_code  (cls_code),
    .rate_match (cls_match)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      prev         <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      rate_code    <= 2'b00;
      rate_match   <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      prev         <= pulse_in;
      period       <= period_d;
      period_valid <= valid_d;
      rate_code    <= code_d;
      rate_match   <= match_d;
      timeout      <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    period_d  = period;
    valid_d   = 1'b0;
    code_d    = rate_code;
    match_d   = rate_match;
    timeout_d = timeout;
    if (clear) begin
      state_d   = IDLE;
      cnt_d     = '0;
      period_d  = '0;
      code_d    = 2'b00;
      match_d   = 1'b0;
      timeout_d = 1'b0;
    end else if (rise) begin
      state_d   = MEASURE;
      cnt_d     = WIDTH'(1);
      timeout_d = 1'b0;
      if (state == MEASURE) begin
        period_d = cnt;
        valid_d  = 1'b1;
        code_d   = cls_code;
        match_d  = cls_match;
      end
    end else if (state == MEASURE) begin
      if (cnt == '1) begin
        state_d   = IDLE;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

endmodule
